// File: rtl/lockstep_compare_pkg.sv
// lockstep_compare_pkg
//   Shared types and helpers for the lockstep comparator:
//   - state_e     : comparator state (WARMUP, ARMED, HALTED)
//   - MODE_*      : cfg_mode encodings
//   - sat_inc     : saturating increment on a 32-bit carrier
package lockstep_compare_pkg;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        ARMED  = 2'd1,
        HALTED = 2'd2
    } state_e;

    localparam logic MODE_STRICT = 1'b0;
    localparam logic MODE_VALID  = 1'b1;

    // Counters up to 32 bits wide are passed zero-extended; the caller
    // truncates the result back to its own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/lockstep_delay_line.sv
// lockstep_delay_line
//   Variable-tap shift register. tap = 0 returns din undelayed, tap = j
//   returns din from j cycles earlier. Taps above DEPTH clamp to DEPTH.
//   Ports:
//     clk, rst : clock, asynchronous active-high reset (contents to 0)
//     din      : WIDTH-bit input sampled every cycle
//     tap      : delay select, 0..DEPTH
//     dout     : selected tap
module lockstep_delay_line #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 3,
    localparam int TAP_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic [TAP_W-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    // sr_q[j] holds din from j+1 cycles ago.
    logic [DEPTH-1:0][WIDTH-1:0] sr_q;
    logic [DEPTH-1:0][WIDTH-1:0] sr_d;
    logic [DEPTH:0][WIDTH-1:0]   taps;
    logic [TAP_W-1:0]            tap_c;

    always_comb begin
        taps  = {sr_q, din};
        sr_d  = taps[DEPTH-1:0];
        tap_c = (tap > TAP_W'(DEPTH)) ? TAP_W'(DEPTH) : tap;
        dout  = taps[tap_c];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sr_q <= '0;
        else     sr_q <= sr_d;
    end

endmodule

// File: rtl/lockstep_compare.sv
// lockstep_compare
//   Runtime lockstep checker for two copies of one block. Copy A is delayed
//   by cfg_skew cycles and compared per channel against copy B. Failures are
//   recorded in sticky flags, a saturating error counter and a first-failure
//   record (lowest failing channel and armed-cycle stamp).
//   Ports:
//     clk, rst          : clock, asynchronous active-high reset
//     a_data/a_valid    : copy A bundles and valids (channel i at i*DATA_WIDTH)
//     b_data/b_valid    : copy B bundles and valids
//     cfg_skew          : lag of B behind A (clamped to SKEW_MAX)
//     cfg_mask          : per-channel compare enable
//     cfg_mode          : 0 strict, 1 valid-qualified
//     cfg_halt          : freeze on first failure
//     clear             : synchronous clear of status, restart warmup
//     armed             : comparisons active
//     mismatch          : sticky per-channel failure flags
//     mismatch_pulse    : one cycle per failing comparison
//     err_count         : failing cycles, saturating
//     first_chan/cycle  : first failure record, qualified by first_valid
module lockstep_compare
    import lockstep_compare_pkg::*;
#(
    parameter  int DATA_WIDTH    = 64,
    parameter  int CHANNELS      = 4,
    parameter  int SKEW_MAX      = 3,
    parameter  int WARMUP_CYCLES = 1,
    parameter  int CNT_WIDTH     = 16,
    localparam int SKEW_W        = $clog2(SKEW_MAX + 1),
    localparam int CH_W          = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS*DATA_WIDTH-1:0] a_data,
    input  logic [CHANNELS-1:0]            a_valid,
    input  logic [CHANNELS*DATA_WIDTH-1:0] b_data,
    input  logic [CHANNELS-1:0]            b_valid,
    input  logic [SKEW_W-1:0]              cfg_skew,
    input  logic [CHANNELS-1:0]            cfg_mask,
    input  logic                           cfg_mode,
    input  logic                           cfg_halt,
    input  logic                           clear,
    output logic                           armed,
    output logic [CHANNELS-1:0]            mismatch,
    output logic                           mismatch_pulse,
    output logic [CNT_WIDTH-1:0]           err_count,
    output logic [CH_W-1:0]                first_chan,
    output logic [CNT_WIDTH-1:0]           first_cycle,
    output logic                           first_valid
);

    localparam int BUS_W = CHANNELS * (DATA_WIDTH + 1);
    localparam int WC_W  = $clog2(WARMUP_CYCLES + SKEW_MAX + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    // ---------------- skew select and A delay line ----------------
    logic [SKEW_W-1:0]              skew_eff;
    logic [BUS_W-1:0]               a_tap;
    logic [CHANNELS-1:0]            a_valid_t;
    logic [CHANNELS*DATA_WIDTH-1:0] a_data_t;

    assign skew_eff = (cfg_skew > SKEW_W'(SKEW_MAX)) ? SKEW_W'(SKEW_MAX) : cfg_skew;

    lockstep_delay_line #(
        .WIDTH (BUS_W),
        .DEPTH (SKEW_MAX)
    ) u_a_dly (
        .clk  (clk),
        .rst  (rst),
        .din  ({a_valid, a_data}),
        .tap  (skew_eff),
        .dout (a_tap)
    );

    assign {a_valid_t, a_data_t} = a_tap;

    // ---------------- per-channel compare ----------------
    logic [CHANNELS-1:0] chan_fail;
    logic [CH_W-1:0]     fail_idx;

    always_comb begin
        chan_fail = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_mode == MODE_STRICT)
                chan_fail[i] = (a_valid_t[i] != b_valid[i]) |
                               (a_data_t[i*DATA_WIDTH +: DATA_WIDTH] !=
                                b_data[i*DATA_WIDTH +: DATA_WIDTH]);
            else
                chan_fail[i] = (a_valid_t[i] != b_valid[i]) |
                               (a_valid_t[i] & b_valid[i] &
                                (a_data_t[i*DATA_WIDTH +: DATA_WIDTH] !=
                                 b_data[i*DATA_WIDTH +: DATA_WIDTH]));
        end
        chan_fail = chan_fail & cfg_mask;
    end

    // Walk downwards so the lowest failing index is the last one written.
    always_comb begin
        fail_idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--)
            if (chan_fail[i]) fail_idx = CH_W'(i);
    end

    // ---------------- state and status ----------------
    state_e               state_q, state_d;
    logic [SKEW_W-1:0]    skew_q, skew_d;
    logic [WC_W-1:0]      wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0] stamp_q, stamp_d;
    logic [CHANNELS-1:0]  mismatch_q, mismatch_d;
    logic                 pulse_q, pulse_d;
    logic [CNT_WIDTH-1:0] err_q, err_d;
    logic [CH_W-1:0]      fchan_q, fchan_d;
    logic [CNT_WIDTH-1:0] fcycle_q, fcycle_d;
    logic                 fvalid_q, fvalid_d;

    logic            restart;
    logic            fail;
    logic [WC_W-1:0] wc_next;
    logic [WC_W-1:0] wc_target;

    // The cycle that sees clear or a skew change counts as the first warmup
    // cycle, so the next warmup index is 1 regardless of the old count.
    assign restart   = clear | ((skew_q != skew_eff) & (state_q != HALTED));
    assign fail      = (state_q == ARMED) & ~restart & (|chan_fail);
    assign wc_next   = (restart ? '0 : wcnt_q) + WC_W'(1);
    assign wc_target = WC_W'(WARMUP_CYCLES) + WC_W'(skew_eff);

    always_comb begin
        state_d    = state_q;
        skew_d     = skew_eff;
        wcnt_d     = wcnt_q;
        stamp_d    = stamp_q;
        mismatch_d = mismatch_q;
        pulse_d    = 1'b0;
        err_d      = err_q;
        fchan_d    = fchan_q;
        fcycle_d   = fcycle_q;
        fvalid_d   = fvalid_q;

        if (clear) begin
            mismatch_d = '0;
            err_d      = '0;
            fchan_d    = '0;
            fcycle_d   = '0;
            fvalid_d   = 1'b0;
        end else if (fail) begin
            mismatch_d = mismatch_q | chan_fail;
            pulse_d    = 1'b1;
            err_d      = CNT_WIDTH'(sat_inc(32'(err_q), 32'(CNT_MAX)));
            if (!fvalid_q) begin
                fchan_d  = fail_idx;
                fcycle_d = stamp_q;
                fvalid_d = 1'b1;
            end
        end

        if (restart || state_q == WARMUP) begin
            if (wc_next >= wc_target) begin
                state_d = ARMED;
                wcnt_d  = '0;
                stamp_d = '0;
            end else begin
                state_d = WARMUP;
                wcnt_d  = wc_next;
            end
        end else if (state_q == ARMED) begin
            stamp_d = CNT_WIDTH'(sat_inc(32'(stamp_q), 32'(CNT_MAX)));
            if (fail && cfg_halt) state_d = HALTED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= WARMUP;
            skew_q     <= '0;
            wcnt_q     <= '0;
            stamp_q    <= '0;
            mismatch_q <= '0;
            pulse_q    <= 1'b0;
            err_q      <= '0;
            fchan_q    <= '0;
            fcycle_q   <= '0;
            fvalid_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            skew_q     <= skew_d;
            wcnt_q     <= wcnt_d;
            stamp_q    <= stamp_d;
            mismatch_q <= mismatch_d;
            pulse_q    <= pulse_d;
            err_q      <= err_d;
            fchan_q    <= fchan_d;
            fcycle_q   <= fcycle_d;
            fvalid_q   <= fvalid_d;
        end
    end

    assign armed          = (state_q == ARMED);
    assign mismatch       = mismatch_q;
    assign mismatch_pulse = pulse_q;
    assign err_count      = err_q;
    assign first_chan     = fchan_q;
    assign first_cycle    = fcycle_q;
    assign first_valid    = fvalid_q;

endmodule

// File: tb/tb_lockstep_compare.sv
// tb_lockstep_compare
//   Directed bench: a vector table for the single-cycle compare function and
//   hand-written sequences for warmup, skew, halt, clear, saturation and reset.
module tb_lockstep_compare;

    localparam int CH = 4;
    localparam int DW = 64;

    logic              clk;
    logic              rst;
    logic [CH*DW-1:0]  a_data, b_data;
    logic [CH-1:0]     a_valid, b_valid;
    logic [1:0]        cfg_skew;
    logic [CH-1:0]     cfg_mask;
    logic              cfg_mode, cfg_halt, clear;

    logic              armed, pulse, fvalid;
    logic [CH-1:0]     mismatch;
    logic [15:0]       err, fcycle;
    logic [1:0]        fchan;

    logic              s_armed, s_pulse, s_fvalid;
    logic [CH-1:0]     s_mismatch;
    logic [3:0]        s_err, s_fcycle;
    logic [1:0]        s_fchan;

    int checks   = 0;
    int failures = 0;

    lockstep_compare #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .SKEW_MAX(3), .WARMUP_CYCLES(1), .CNT_WIDTH(16)
    ) dut (
        .clk(clk), .rst(rst), .a_data(a_data), .a_valid(a_valid), .b_data(b_data),
        .b_valid(b_valid), .cfg_skew(cfg_skew), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
        .cfg_halt(cfg_halt), .clear(clear), .armed(armed), .mismatch(mismatch),
        .mismatch_pulse(pulse), .err_count(err), .first_chan(fchan),
        .first_cycle(fcycle), .first_valid(fvalid)
    );

    // Narrow-counter copy on the same inputs, used for the saturation case.
    lockstep_compare #(
        .DATA_WIDTH(DW), .CHANNELS(CH), .SKEW_MAX(3), .WARMUP_CYCLES(1), .CNT_WIDTH(4)
    ) dut_sat (
        .clk(clk), .rst(rst), .a_data(a_data), .a_valid(a_valid), .b_data(b_data),
        .b_valid(b_valid), .cfg_skew(cfg_skew), .cfg_mask(cfg_mask), .cfg_mode(cfg_mode),
        .cfg_halt(cfg_halt), .clear(clear), .armed(s_armed), .mismatch(s_mismatch),
        .mismatch_pulse(s_pulse), .err_count(s_err), .first_chan(s_fchan),
        .first_cycle(s_fcycle), .first_valid(s_fvalid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mode;
        logic [3:0] mask;
        logic [3:0] av;
        logic [3:0] bv;
        logic [3:0] diff;
        logic [3:0] exp;
        logic [1:0] exp_first;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] gen(input int n, input int ch);
        return {16'hC0DE, 16'(ch), 32'(n)};
    endfunction

    // A carries stream element t, B carries element t-k (invalid zero before 0).
    task automatic drive_stream(input int t, input int k);
        a_valid = '1;
        b_valid = (t - k >= 0) ? '1 : '0;
        for (int i = 0; i < CH; i++) begin
            a_data[i*DW +: DW] = gen(t, i);
            b_data[i*DW +: DW] = (t - k >= 0) ? gen(t - k, i) : 64'd0;
        end
    endtask

    task automatic drive_zero();
        a_data  = '0;
        b_data  = '0;
        a_valid = '1;
        b_valid = '1;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'b0000, 4'b0000, 2'd0};
        vecs[1]  = '{1'b0, 4'hF, 4'hF, 4'hF, 4'b0100, 4'b0100, 2'd2};
        vecs[2]  = '{1'b0, 4'hF, 4'h0, 4'h0, 4'b0011, 4'b0011, 2'd0};
        vecs[3]  = '{1'b1, 4'hF, 4'h0, 4'h0, 4'b0011, 4'b0000, 2'd0};
        vecs[4]  = '{1'b1, 4'hF, 4'hF, 4'hF, 4'b1000, 4'b1000, 2'd3};
        vecs[5]  = '{1'b1, 4'hF, 4'b0101, 4'b0100, 4'b0000, 4'b0001, 2'd0};
        vecs[6]  = '{1'b1, 4'hF, 4'b0101, 4'b0101, 4'b1010, 4'b0000, 2'd0};
        vecs[7]  = '{1'b0, 4'b1011, 4'hF, 4'hF, 4'b0100, 4'b0000, 2'd0};
        vecs[8]  = '{1'b0, 4'b1011, 4'hF, 4'hF, 4'b1110, 4'b1010, 2'd1};
        vecs[9]  = '{1'b1, 4'b0001, 4'hF, 4'hE, 4'b1111, 4'b0001, 2'd0};
        vecs[10] = '{1'b0, 4'hF, 4'hF, 4'hF, 4'b1111, 4'b1111, 2'd0};

        rst = 1'b1; clear = 1'b0; cfg_skew = 2'd0; cfg_mask = 4'hF;
        cfg_mode = 1'b0; cfg_halt = 1'b0;
        drive_zero();
        repeat (3) tick();

        // ---- reset state ----
        chk("rst_armed", 64'(armed), 64'd0);
        chk("rst_mismatch", 64'(mismatch), 64'd0);
        chk("rst_pulse", 64'(pulse), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_fchan", 64'(fchan), 64'd0);
        chk("rst_fcycle", 64'(fcycle), 64'd0);
        chk("rst_fvalid", 64'(fvalid), 64'd0);

        // ---- identical streams, skew 0: armed at cycle 1, no errors ----
        rst = 1'b0;
        for (int t = 0; t <= 100; t++) begin
            if (t == 0) chk("s0_armed_c0", 64'(armed), 64'd0);
            if (t == 1) chk("s0_armed_c1", 64'(armed), 64'd1);
            drive_stream(t, 0);
            tick();
        end
        chk("s0_err", 64'(err), 64'd0);
        chk("s0_mismatch", 64'(mismatch), 64'd0);
        chk("s0_fvalid", 64'(fvalid), 64'd0);

        // ---- skew 2, corrupt channel 2 at armed cycle 5 (cycle 8) ----
        rst = 1'b1; cfg_skew = 2'd2;
        tick(); tick();
        rst = 1'b0;
        for (int t = 0; t <= 12; t++) begin
            if (t == 2) chk("s1_armed_c2", 64'(armed), 64'd0);
            if (t == 3) chk("s1_armed_c3", 64'(armed), 64'd1);
            drive_stream(t, 2);
            if (t == 8) b_data[2*DW] = ~b_data[2*DW];
            tick();
            if (t == 7) chk("s1_quiet_before", 64'(err), 64'd0);
            if (t == 8) begin
                chk("s1_mismatch", 64'(mismatch), 64'b0100);
                chk("s1_fchan", 64'(fchan), 64'd2);
                chk("s1_fcycle", 64'(fcycle), 64'd5);
                chk("s1_err", 64'(err), 64'd1);
                chk("s1_pulse", 64'(pulse), 64'd1);
                chk("s1_fvalid", 64'(fvalid), 64'd1);
            end
            if (t == 9) begin
                chk("s1_pulse_off", 64'(pulse), 64'd0);
                chk("s1_err_hold", 64'(err), 64'd1);
            end
        end

        // ---- compare-function table: clear, then one armed vector cycle ----
        cfg_skew = 2'd0;
        for (int v = 0; v < 11; v++) begin
            drive_zero();
            clear = 1'b1;
            tick();
            clear = 1'b0;
            chk($sformatf("v%0d_armed", v), 64'(armed), 64'd1);
            cfg_mode = vecs[v].mode;
            cfg_mask = vecs[v].mask;
            a_valid  = vecs[v].av;
            b_valid  = vecs[v].bv;
            for (int i = 0; i < CH; i++) begin
                a_data[i*DW +: DW] = gen(v, i);
                b_data[i*DW +: DW] = gen(v, i) ^ (vecs[v].diff[i] ? 64'h10 : 64'h0);
            end
            tick();
            chk($sformatf("v%0d_mismatch", v), 64'(mismatch), 64'(vecs[v].exp));
            chk($sformatf("v%0d_pulse", v), 64'(pulse), 64'(|vecs[v].exp));
            chk($sformatf("v%0d_err", v), 64'(err), 64'(|vecs[v].exp));
            chk($sformatf("v%0d_fvalid", v), 64'(fvalid), 64'(|vecs[v].exp));
            if (vecs[v].exp != 4'b0000)
                chk($sformatf("v%0d_fchan", v), 64'(fchan), 64'(vecs[v].exp_first));
        end

        // ---- both valids low, differing data: valid mode quiet, strict fails ----
        cfg_mask = 4'hF; cfg_mode = 1'b1;
        drive_zero();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        a_valid = '0; b_valid = '0;
        a_data = {CH{64'h1111_2222_3333_4444}};
        b_data = {CH{64'h5555_6666_7777_8888}};
        repeat (5) tick();
        chk("vq_err", 64'(err), 64'd0);
        chk("vq_mismatch", 64'(mismatch), 64'd0);
        cfg_mode = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            chk($sformatf("st_pulse%0d", n), 64'(s_pulse), 64'd1);
            if (n == 14) chk("sat_err14", 64'(s_err), 64'd14);
            if (n == 15) chk("sat_err15", 64'(s_err), 64'd15);
        end
        chk("st_err20", 64'(err), 64'd20);
        chk("sat_err20", 64'(s_err), 64'd15);
        chk("st_pulse_main", 64'(pulse), 64'd1);
        chk("st_mismatch", 64'(mismatch), 64'hF);

        // ---- halt on ch1+ch3 failing together ----
        cfg_halt = 1'b1;
        drive_zero();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        b_data[1*DW] = 1'b1;
        b_data[3*DW] = 1'b1;
        tick();
        chk("h_fchan", 64'(fchan), 64'd1);
        chk("h_mismatch", 64'(mismatch), 64'b1010);
        chk("h_err", 64'(err), 64'd1);
        chk("h_armed", 64'(armed), 64'd0);
        chk("h_fcycle", 64'(fcycle), 64'd0);
        b_data[0] = 1'b1;
        repeat (4) tick();
        chk("h_err_frozen", 64'(err), 64'd1);
        chk("h_mismatch_frozen", 64'(mismatch), 64'b1010);
        cfg_skew = 2'd2;
        tick();
        chk("h_skew_ignored", 64'(armed), 64'd0);

        // ---- clear out of HALTED with skew 2: armed 3 cycles after clear ----
        drive_zero();
        cfg_halt = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("c_err", 64'(err), 64'd0);
        chk("c_mismatch", 64'(mismatch), 64'd0);
        chk("c_fvalid", 64'(fvalid), 64'd0);
        chk("c_fchan", 64'(fchan), 64'd0);
        chk("c_armed1", 64'(armed), 64'd0);
        tick();
        chk("c_armed2", 64'(armed), 64'd0);
        tick();
        chk("c_armed3", 64'(armed), 64'd1);

        // ---- skew change while armed: rewarm, status kept ----
        b_data[0] = 1'b1;
        tick();
        chk("k_mismatch", 64'(mismatch), 64'b0001);
        b_data[0] = 1'b0;
        cfg_skew = 2'd1;
        tick();
        chk("k_armed_drop", 64'(armed), 64'd0);
        chk("k_mismatch_kept", 64'(mismatch), 64'b0001);
        chk("k_err_kept", 64'(err), 64'd1);
        tick();
        chk("k_armed_back", 64'(armed), 64'd1);

        // ---- asynchronous reset mid-stream ----
        b_data[3*DW] = 1'b1;
        tick(); tick();
        chk("r_err_pre", 64'(err), 64'd3);
        #3 rst = 1'b1;
        #1;
        chk("r_armed", 64'(armed), 64'd0);
        chk("r_mismatch", 64'(mismatch), 64'd0);
        chk("r_pulse", 64'(pulse), 64'd0);
        chk("r_err", 64'(err), 64'd0);
        chk("r_fvalid", 64'(fvalid), 64'd0);
        chk("r_fcycle", 64'(fcycle), 64'd0);
        chk("r_sat_err", 64'(s_err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
